// File: rtl/burst_pulse_gen_if.sv
// burst_pulse_gen_if: control/status bundle between register block and burst pulse generator
interface burst_pulse_gen_if #(
  parameter int CNT_W = 8,
  parameter int DIV_W = 4,
  parameter int REP_W = 4
);
  logic             start;
  logic             abort;
  logic [1:0]       mode;
  logic [CNT_W-1:0] len;
  logic [DIV_W-1:0] half_div;
  logic [REP_W-1:0] reps;
  logic             out_pulse;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] count;
  logic [REP_W-1:0] rep_idx;
  modport master (
    output start, abort, mode, len, half_div, reps,
    input  out_pulse, busy, done, count, rep_idx
  );
  modport slave (
    input  start, abort, mode, len, half_div, reps,
    output out_pulse, busy, done, count, rep_idx
  );
endinterface

// File: rtl/burst_pulse_gen.sv
// burst_pulse_gen: counted burst of a divided square wave with oneshot/repeat/continuous modes
module burst_pulse_gen #(
  parameter int CNT_W = 8,
  parameter int DIV_W = 4,
  parameter int REP_W = 4
) (
  input logic               clk,
  input logic               rst,
  burst_pulse_gen_if.slave  bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  logic [0:0]       state;
  logic [1:0]       m;
  logic [CNT_W-1:0] l_last;
  logic [DIV_W-1:0] h_last;
  logic [REP_W-1:0] r_last;
  logic [DIV_W-1:0] div;
  logic             last;
  logic             again;
  // end-of-burst detection and whether the run continues with another burst
  always_comb begin
    last  = bus.count == l_last;
    again = m == 2'b10 || (m == 2'b01 && bus.rep_idx != r_last);
  end
  // shadow config is stored as limit-minus-one so zero settings clamp to one
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      m             <= '0;
      l_last        <= '0;
      h_last        <= '0;
      r_last        <= '0;
      div           <= '0;
      bus.out_pulse <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.count     <= '0;
      bus.rep_idx   <= '0;
    end else if (state == IDLE) begin
      bus.done <= 1'b0;
      if (bus.start && !bus.abort) begin
        state    <= RUN;
        m        <= bus.mode;
        l_last   <= bus.len == '0 ? '0 : bus.len - 1'b1;
        h_last   <= bus.half_div == '0 ? '0 : bus.half_div - 1'b1;
        r_last   <= bus.reps == '0 ? '0 : bus.reps - 1'b1;
        bus.busy <= 1'b1;
      end
    end else if (bus.abort || (last && !again)) begin
      state         <= IDLE;
      div           <= '0;
      bus.out_pulse <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= !bus.abort;
      bus.count     <= '0;
      bus.rep_idx   <= '0;
    end else if (last) begin
      div           <= '0;
      bus.out_pulse <= 1'b0;
      bus.count     <= '0;
      bus.rep_idx   <= m == 2'b10 ? '0 : bus.rep_idx + 1'b1;
    end else begin
      div           <= div == h_last ? '0 : div + 1'b1;
      bus.out_pulse <= bus.out_pulse ^ (div == h_last);
      bus.count     <= bus.count + 1'b1;
    end
  end
endmodule
